// File: rtl/bus_responder_if.sv
// Request/response bundle between a bus controller (master) and bus_responder (slave).
// rerr exists only when BUS_RESP_ERR_EN is defined.
interface bus_responder_if;
  logic        BUS_data_valid;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
`ifdef BUS_RESP_ERR_EN
  logic        rerr;

  modport master (output BUS_data_valid, we, addr, wdata,
                  input  ready, rvalid, rdata, rerr);
  modport slave  (input  BUS_data_valid, we, addr, wdata,
                  output ready, rvalid, rdata, rerr);
`else
  modport master (output BUS_data_valid, we, addr, wdata,
                  input  ready, rvalid, rdata);
  modport slave  (input  BUS_data_valid, we, addr, wdata,
                  output ready, rvalid, rdata);
`endif
endinterface

// File: rtl/bus_responder.sv
// Single-outstanding register-file responder with programmable wait states.
// Optional error response (misaligned or unmapped access) enabled by macro BUS_RESP_ERR_EN.
module bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          NREGS       = 8,
  parameter int          WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  bus_responder_if.slave bus
);

  localparam int          IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * NREGS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;

  logic [31:0] regs [NREGS];

  logic [31:0]      offset;
  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             wr_ok;
  logic             accept;

  // Decode from the latched address; the subtraction wraps addresses below
  // BASE_ADDR to large offsets, so one compare covers both bounds.
  assign offset = lat_addr - BASE_ADDR;
  assign hit    = (offset < SPAN);
  assign idx    = offset[IDX_W+1:2];
  assign accept = (state == IDLE) && bus.BUS_data_valid;

`ifdef BUS_RESP_ERR_EN
  logic err;
  assign err   = !hit || (lat_addr[1:0] != 2'b00);
  assign wr_ok = lat_we && !err;
`else
  assign wr_ok = lat_we && hit;
`endif

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.BUS_data_valid) begin
          cnt_nxt   = WAIT_LOAD;
          state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_we    <= 1'b0;
      // NOTE: the register file must read back zero after reset, so it is
      // built from resettable flops rather than an inferred RAM.
      for (int i = 0; i < NREGS; i++) regs[i] <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_addr  <= bus.addr;
        lat_wdata <= bus.wdata;
        lat_we    <= bus.we;
      end
      // Commit on the edge leaving RESP; a reset during WAIT/RESP never gets here.
      if (state == RESP && wr_ok) regs[idx] <= lat_wdata;
    end
  end

  assign bus.ready  = (state == IDLE);
  assign bus.rvalid = (state == RESP);
  assign bus.rdata  = (bus.rvalid && !lat_we && hit) ? regs[idx] : 32'h0;
`ifdef BUS_RESP_ERR_EN
  assign bus.rerr   = bus.rvalid && err;
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder: one instance with 2 wait
// states and one with none; error checks are active when BUS_RESP_ERR_EN is defined.
module tb_bus_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_responder_if b0 ();
  bus_responder_if b1 ();

  bus_responder #(.BASE_ADDR(32'h1000_0000), .NREGS(8), .WAIT_CYCLES(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  bus_responder #(.BASE_ADDR(32'h1000_0000), .NREGS(8), .WAIT_CYCLES(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int which);
    return (which != 0) ? b1.ready : b0.ready;
  endfunction

  function automatic logic rv(input int which);
    return (which != 0) ? b1.rvalid : b0.rvalid;
  endfunction

  function automatic logic [31:0] rdat(input int which);
    return (which != 0) ? b1.rdata : b0.rdata;
  endfunction

  function automatic logic rer(input int which);
`ifdef BUS_RESP_ERR_EN
    return (which != 0) ? b1.rerr : b0.rerr;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input int which, input logic v, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (which != 0) begin
      b1.BUS_data_valid = v; b1.we = w; b1.addr = a; b1.wdata = d;
    end else begin
      b0.BUS_data_valid = v; b0.we = w; b0.addr = a; b0.wdata = d;
    end
  endtask

  // One request; lat counts negedges after the accepting edge until rvalid (0 = timeout).
  task automatic txn(input int which, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output int lat, output logic er);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!rdy(which) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", 32'(rdy(which)), 32'd1);
    drive(which, 1'b1, w, a, d);
    @(posedge clk);
    #1 drive(which, 1'b0, w, a, d);
    lat = 0; rd = 32'h0; er = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rv(which)) begin
        lat = c;
        rd  = rdat(which);
        er  = rer(which);
        break;
      end
      check("rdata_zero_no_rvalid", rdat(which), 32'h0);
    end
    if (lat != 0) begin
      @(negedge clk);
      check("rvalid_one_cycle", 32'(rv(which)), 32'd0);
    end
  endtask

  logic [31:0] rd;
  int          lat;
  logic        er;
  logic [31:0] exp_q [$];
  int          n_acc, n_rv, last_acc;

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  32'(b0.ready),  32'd1);
    check("rst_rvalid", 32'(b0.rvalid), 32'd0);
    check("rst_rdata",  b0.rdata,       32'h0);
    rst = 1'b0;

    // Write then read back with 2 wait states
    txn(0, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF, rd, lat, er);
    check("wr08_lat",   32'(lat), 32'd3);
    check("wr08_rdata", rd,       32'h0);
    txn(0, 1'b0, 32'h1000_0008, 32'h0, rd, lat, er);
    check("rd08_lat",   32'(lat), 32'd3);
    check("rd08_rdata", rd,       32'hDEAD_BEEF);
`ifdef BUS_RESP_ERR_EN
    check("rd08_rerr",  32'(er),  32'd0);
`endif

    // Misses above and below the window
    txn(0, 1'b0, 32'h1000_0020, 32'h0, rd, lat, er);
    check("miss_hi_lat",   32'(lat), 32'd3);
    check("miss_hi_rdata", rd,       32'h0);
`ifdef BUS_RESP_ERR_EN
    check("miss_hi_rerr",  32'(er),  32'd1);
`endif
    txn(0, 1'b0, 32'h0FFF_FFFC, 32'h0, rd, lat, er);
    check("miss_lo_rdata", rd, 32'h0);

    // Write miss must not alias onto register 0
    txn(0, 1'b1, 32'h1000_0020, 32'h1111_2222, rd, lat, er);
    txn(0, 1'b0, 32'h1000_0000, 32'h0, rd, lat, er);
    check("wmiss_no_alias", rd, 32'h0);

    // Last register in the window
    txn(0, 1'b1, 32'h1000_001C, 32'hA5A5_0001, rd, lat, er);
    txn(0, 1'b0, 32'h1000_001C, 32'h0, rd, lat, er);
    check("rd1c_rdata", rd, 32'hA5A5_0001);

    // Misaligned write
`ifdef BUS_RESP_ERR_EN
    txn(0, 1'b1, 32'h1000_0001, 32'h0000_0005, rd, lat, er);
    check("misal_wr_rerr", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h1000_0000, 32'h0, rd, lat, er);
    check("misal_no_commit", rd, 32'h0);
`else
    txn(0, 1'b1, 32'h1000_0001, 32'h0000_0005, rd, lat, er);
    txn(0, 1'b0, 32'h1000_0003, 32'h0, rd, lat, er);
    check("misal_rd03", rd, 32'h0000_0005);
    txn(0, 1'b0, 32'h1000_0000, 32'h0, rd, lat, er);
    check("misal_rd00", rd, 32'h0000_0005);
`endif

    // Continuous valid with alternating read addresses: accept every 4 cycles
    n_acc = 0; n_rv = 0; last_acc = -1;
    exp_q.delete();
    b0.BUS_data_valid = 1'b1;
    b0.we = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (b0.rvalid) begin
        n_rv++;
        if (exp_q.size() > 0) check("b2b_rdata", b0.rdata, exp_q.pop_front());
        else check("b2b_extra_rvalid", 32'(b0.rvalid), 32'd0);
      end else begin
        check("b2b_rdata_zero", b0.rdata, 32'h0);
      end
      if (b0.ready) begin
        if (last_acc >= 0) check("b2b_interval", 32'(c - last_acc), 32'd4);
        last_acc = c;
        b0.addr = n_acc[0] ? 32'h1000_001C : 32'h1000_0008;
        exp_q.push_back(n_acc[0] ? 32'hA5A5_0001 : 32'hDEAD_BEEF);
        n_acc++;
      end
      @(negedge clk);
      if (c == 15) b0.BUS_data_valid = 1'b0;
    end
    check("b2b_accepts", 32'(n_acc), 32'd4);
    check("b2b_rvalids", 32'(n_rv),  32'd4);

    // Reset during WAIT aborts a pending write and clears the registers
    while (!b0.ready) @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h1000_0004, 32'h1234_5678);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b1, 32'h1000_0004, 32'h1234_5678);
    @(negedge clk);
    check("abort_in_wait", 32'(b0.ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rvalid", 32'(b0.rvalid), 32'd0);
    check("abort_ready",  32'(b0.ready),  32'd1);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_rvalid", 32'(b0.rvalid), 32'd0);
    end
    txn(0, 1'b0, 32'h1000_0004, 32'h0, rd, lat, er);
    check("abort_rd04", rd, 32'h0);
    txn(0, 1'b0, 32'h1000_0008, 32'h0, rd, lat, er);
    check("rst_cleared_rd08", rd, 32'h0);

    // Zero-wait instance
    txn(1, 1'b1, 32'h1000_001C, 32'hA5A5_A5A5, rd, lat, er);
    check("w0_wr_lat", 32'(lat), 32'd1);
    txn(1, 1'b0, 32'h1000_001C, 32'h0, rd, lat, er);
    check("w0_rd_lat",   32'(lat), 32'd1);
    check("w0_rd_rdata", rd,       32'hA5A5_A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
